// File: rtl/di_arb_pkg.sv
// Shared types and widths for the device-interface bus arbiter.
package di_arb_pkg;

  localparam int EP_W   = 16;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/di_arbiter.sv
// Round-robin arbiter sharing the device-interface register bus between the
// host command decoder (master 0) and the on-chip register sequencer (master 1).
//
// state | meaning
// IDLE  | sample requests, grant and latch the winner's fields
// ISSUE | single-cycle diWrite/diRead strobe
// WAIT  | wait for rdwr_ready, abort with error after TIMEOUT cycles
// DONE  | one-cycle ack with rdata/err to the granted master
module di_arbiter
  import di_arb_pkg::*;
#(
  parameter int                TIMEOUT  = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              if_clock,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [EP_W-1:0]   m0_ep,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [EP_W-1:0]   m1_ep,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  output logic [EP_W-1:0]   diEpAddr,
  output logic [ADDR_W-1:0] diRegAddr,
  output logic [DATA_W-1:0] diRegDataIn,
  output logic              diWrite,
  output logic              diRead,
  input  logic [DATA_W-1:0] diRegDataOut,
  input  logic              rdwr_ready,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q;
  logic              last_grant_q;
  logic              gnt_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              pick_m1;
  logic [DATA_W-1:0] done_data;
  logic              done_err;

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    pick_m1   = m1_req && (!m0_req || !last_grant_q);
    done_err  = !rdwr_ready;
    done_data = '0;
    if (!wr_q) done_data = rdwr_ready ? diRegDataOut : ERR_DATA;
  end

  always_ff @(posedge if_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      m0_ack       <= 1'b0;
      m0_rdata     <= '0;
      m0_err       <= 1'b0;
      m1_ack       <= 1'b0;
      m1_rdata     <= '0;
      m1_err       <= 1'b0;
      diEpAddr     <= '0;
      diRegAddr    <= '0;
      diRegDataIn  <= '0;
      diWrite      <= 1'b0;
      diRead       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      diWrite <= 1'b0;
      diRead  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q       <= pick_m1;
            wr_q        <= pick_m1 ? m1_write : m0_write;
            diEpAddr    <= pick_m1 ? m1_ep    : m0_ep;
            diRegAddr   <= pick_m1 ? m1_addr  : m0_addr;
            diRegDataIn <= pick_m1 ? m1_wdata : m0_wdata;
            diWrite     <= pick_m1 ? m1_write : m0_write;
            diRead      <= pick_m1 ? !m1_write : !m0_write;
            busy        <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (rdwr_ready || cnt_q == CNT_LAST) begin
            if (gnt_q) begin
              m1_ack   <= 1'b1;
              m1_rdata <= done_data;
              m1_err   <= done_err;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= done_data;
              m0_err   <= done_err;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          m0_rdata     <= '0;
          m0_err       <= 1'b0;
          m1_rdata     <= '0;
          m1_err       <= 1'b0;
          last_grant_q <= gnt_q;
          busy         <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
